hazard_scoreboard_unit: RTL
===========================

Name: hazard_scoreboard_unit

Overview:
Second-generation hazard unit for the 5-stage pipeline (F/D/E/M/W).
- Keeps combinational forwarding, load-use stall and branch flush.
- Adds variable-latency multi-cycle ops in E (counter FSM), data-memory wait stalls (memReady handshake), per-stage stall/flush outputs and a saturating stall-cycle counter.
- Sits beside the pipeline registers and drives their stall/flush enables and the E-stage operand muxes.

Parameters:
ADDRESSWIDTH, 4, register address width
MAXLATENCY, 8, max multi-cycle op latency in cycles (>=2)
ZEROREG_EN, 0, 1 = register 0 is hardwired; never matches for forwarding/hazards
COUNTWIDTH, 16, stall-cycle counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
reg1ReadAddressD, reg2ReadAddressD  in  ADDRESSWIDTH  D-stage source regs
reg1ReadAddressE, reg2ReadAddressE  in  ADDRESSWIDTH  E-stage source regs
writeAddressE, writeAddressM, writeAddressW  in  ADDRESSWIDTH  destination regs per stage
writeEnableE, writeEnableM, writeEnableW  in  1  register-write enables per stage
resultSelectorWBE  in  1  E instruction is a load
multiCycleE  in  1  E instruction is a multi-cycle op
latencyE  in  $clog2(MAXLATENCY+1)  cycles the op occupies E
memAccessM, memReadyM  in  1  M is a memory access / memory ready
takeBranchE  in  1  branch resolved taken in E
data1ForwardSelectorE, data2ForwardSelectorE  out  2  00 regfile, 01 W, 10 M
stallF, stallD, stallE, stallM  out  1  hold stage register
flushD, flushE, flushM, flushW  out  1  insert bubble into stage register
mcBusy  out  1  state == MC_BUSY
stallCount  out  COUNTWIDTH  cycles with stallF=1, saturating

Behaviour:
- Reset (rst=1 at clk edge):
  - state <= IDLE, cnt <= 0, stallCount <= 0.
  - While rst=1, all stall/flush outputs are 0 and selectors are 00.
  - Reset mid MC_BUSY returns to IDLE next cycle; the op is abandoned.
- match(a,b): a==b and, if ZEROREG_EN, a!=0.
- Forwarding (combinational):
  - M has priority over W: writeEnableM && match(regXE, writeAddressM) -> 10.
  - Else writeEnableW && match(regXE, writeAddressW) -> 01.
  - Else 00.
- memStall = memAccessM && !memReadyM.
  - Asserts stallF/D/E/M and flushW.
  - Overrides everything else: no branch, load-use or MC flush while memStall.
- Load-use:
  - ldStall = writeEnableE && resultSelectorWBE && match(either D source, writeAddressE).
  - Effect: stallF, stallD, flushE for one cycle.
- Multi-cycle FSM, states IDLE and MC_BUSY.
  - Effective latency L = max(latencyE, 1); L > MAXLATENCY clamps to MAXLATENCY.
  - IDLE:
    - multiCycleE && L>=2: mcStall combinationally this cycle; cnt <= L-1; go to MC_BUSY.
    - L<=1: no action.
  - MC_BUSY:
    - mcStall = (cnt>1).
    - cnt decrements each cycle, saturating at 1.
    - cnt==1 and !memStall: final cycle, no mcStall; next state IDLE.
    - cnt==1 and memStall: remain in MC_BUSY with cnt==1 until memStall clears.
    - A new op cannot trigger from MC_BUSY.
  - Total E occupancy = L cycles when there is no memStall.
  - mcStall asserts stallF/D/E and flushM.
- Branch: takeBranchE && !memStall -> flushD, flushE.
  - Forces stallF=stallD=0 that cycle, overriding ldStall.
  - Multi-cycle ops never branch; branch with mcStall=1 is a don't-care.
- Composition:
  - stallF = memStall | ((ldStall|mcStall) & !branch); stallD is identical.
  - stallE = memStall | mcStall; stallM = memStall.
- stallCount increments on each cycle with stallF=1 and saturates at all-ones.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mc_state_t enum: IDLE, MC_BUSY.
  - Helper function for the ZEROREG_EN-aware match.
- One sub-module, mc_latency_counter: holds the FSM and cnt; outputs mcStall and mcBusy.
- Forwarding and stall/flush composition stay in the top.

Test Plan:
- Forwarding: writeEnableM=1, writeAddressM=3, writeEnableW=1, writeAddressW=3, reg1ReadAddressE=3 -> data1ForwardSelectorE=10; drop writeEnableM -> 01; ZEROREG_EN=1 with all addresses 0 -> 00.
- Load-use: resultSelectorWBE=1, writeEnableE=1, writeAddressE=5, reg2ReadAddressD=5 -> stallF=stallD=flushE=1 for exactly one cycle; writeEnableE=0 -> no stall.
- Multi-cycle, latencyE=4, multiCycleE held -> stallE=1 for 3 cycles, flushM=1 for 3 cycles, mcBusy=1 for 3 cycles, release on 4th; latencyE=1 -> no stall; latencyE=12 with MAXLATENCY=8 -> 7 stall cycles.
- memReadyM=0 for 2 cycles during MC_BUSY final cycle -> stallF/D/E/M=1, flushW=1, state held with cnt=1, exit one cycle after memReadyM=1.
- takeBranchE=1 with ldStall=1 -> flushD=flushE=1, stallF=stallD=0; same with memStall=1 -> flushD=flushE=0, stalls held.
- rst asserted mid MC_BUSY -> next cycle mcBusy=0, stallCount=0, all outputs 0; stallCount saturates at 0xFFFF under a long memStall (COUNTWIDTH=16).

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard scoreboard unit.
//   fwd_sel_t   - E-stage operand source select (regfile / W / M)
//   mc_state_t  - multi-cycle occupancy FSM states
//   reg_match() - register address compare that honours a hardwired register 0
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // Widest register address the compare helper accepts; callers zero-extend.
  localparam int ADDR_MAX_W = 32;

  // True when a and b name the same register; register 0 never matches when
  // it is hardwired, since writes to it are discarded.
  function automatic logic reg_match(input logic [ADDR_MAX_W-1:0] a,
                                     input logic [ADDR_MAX_W-1:0] b,
                                     input logic                  zero_en);
    logic hit_v;
    if (zero_en && (a == {ADDR_MAX_W{1'b0}})) begin
      hit_v = 1'b0;
    end else begin
      hit_v = (a == b);
    end
    return hit_v;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: pipeline <-> hazard unit signal bundle.
//   master modport: pipeline side (drives stage addresses/enables, receives
//                   stall/flush/forward controls and status)
//   slave modport : hazard unit side
interface hazard_scoreboard_unit_if #(
  parameter int ADDRESSWIDTH = 4,
  parameter int MAXLATENCY   = 8,
  parameter int COUNTWIDTH   = 16
);
  localparam int LATW = $clog2(MAXLATENCY + 1);

  logic [ADDRESSWIDTH-1:0] reg1ReadAddressD;
  logic [ADDRESSWIDTH-1:0] reg2ReadAddressD;
  logic [ADDRESSWIDTH-1:0] reg1ReadAddressE;
  logic [ADDRESSWIDTH-1:0] reg2ReadAddressE;
  logic [ADDRESSWIDTH-1:0] writeAddressE;
  logic [ADDRESSWIDTH-1:0] writeAddressM;
  logic [ADDRESSWIDTH-1:0] writeAddressW;
  logic                    writeEnableE;
  logic                    writeEnableM;
  logic                    writeEnableW;
  logic                    resultSelectorWBE;
  logic                    multiCycleE;
  logic [LATW-1:0]         latencyE;
  logic                    memAccessM;
  logic                    memReadyM;
  logic                    takeBranchE;

  logic [1:0]              data1ForwardSelectorE;
  logic [1:0]              data2ForwardSelectorE;
  logic                    stallF;
  logic                    stallD;
  logic                    stallE;
  logic                    stallM;
  logic                    flushD;
  logic                    flushE;
  logic                    flushM;
  logic                    flushW;
  logic                    mcBusy;
  logic [COUNTWIDTH-1:0]   stallCount;

  modport master (
    output reg1ReadAddressD, reg2ReadAddressD, reg1ReadAddressE, reg2ReadAddressE,
           writeAddressE, writeAddressM, writeAddressW,
           writeEnableE, writeEnableM, writeEnableW,
           resultSelectorWBE, multiCycleE, latencyE,
           memAccessM, memReadyM, takeBranchE,
    input  data1ForwardSelectorE, data2ForwardSelectorE,
           stallF, stallD, stallE, stallM,
           flushD, flushE, flushM, flushW,
           mcBusy, stallCount
  );

  modport slave (
    input  reg1ReadAddressD, reg2ReadAddressD, reg1ReadAddressE, reg2ReadAddressE,
           writeAddressE, writeAddressM, writeAddressW,
           writeEnableE, writeEnableM, writeEnableW,
           resultSelectorWBE, multiCycleE, latencyE,
           memAccessM, memReadyM, takeBranchE,
    output data1ForwardSelectorE, data2ForwardSelectorE,
           stallF, stallD, stallE, stallM,
           flushD, flushE, flushM, flushW,
           mcBusy, stallCount
  );
endinterface

// File: rtl/hazard_scoreboard_unit_mc_latency_counter.sv
// mc_latency_counter: tracks how long a multi-cycle op still occupies E.
//   clk, rst    - clock, synchronous active-high reset
//   multi_cycle - E holds a multi-cycle op
//   latency     - requested occupancy in cycles (0 treated as 1, clamped to MAXLATENCY)
//   mem_stall   - M is waiting on memory; the op may not leave E meanwhile
//   mc_stall    - E must hold this cycle because the op is not yet finished
//   mc_busy     - FSM is in MC_BUSY
module mc_latency_counter
  import hazard_pkg::*;
#(
  parameter int MAXLATENCY = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            multi_cycle,
  input  logic [$clog2(MAXLATENCY+1)-1:0] latency,
  input  logic                            mem_stall,
  output logic                            mc_stall,
  output logic                            mc_busy
);
  localparam int LATW = $clog2(MAXLATENCY + 1);

  mc_state_t       state_r;
  mc_state_t       state_nxt_s;
  logic [LATW-1:0] cnt_r;
  logic [LATW-1:0] cnt_nxt_s;
  logic [LATW-1:0] eff_lat_s;
  logic            mc_stall_s;

  // Effective latency: at least one cycle, at most MAXLATENCY.
  always_comb begin
    eff_lat_s = latency;
    if (latency == LATW'(0)) begin
      eff_lat_s = LATW'(1);
    end else if (latency > LATW'(MAXLATENCY)) begin
      eff_lat_s = LATW'(MAXLATENCY);
    end else begin
      eff_lat_s = latency;
    end
  end

  // Next-state and stall decode; cnt counts the E cycles still owed, the
  // trigger cycle already being the first of the L cycles.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mc_stall_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (multi_cycle && (eff_lat_s >= LATW'(2))) begin
          mc_stall_s  = 1'b1;
          cnt_nxt_s   = eff_lat_s - LATW'(1);
          state_nxt_s = MC_BUSY;
        end else begin
          cnt_nxt_s   = LATW'(0);
        end
      end
      MC_BUSY: begin
        if (cnt_r > LATW'(1)) begin
          mc_stall_s = 1'b1;
          cnt_nxt_s  = cnt_r - LATW'(1);
        end else if (mem_stall) begin
          // Final cycle blocked by memory: park at 1 until M drains.
          cnt_nxt_s  = LATW'(1);
        end else begin
          cnt_nxt_s   = LATW'(0);
          state_nxt_s = IDLE;
        end
      end
      default: begin
        cnt_nxt_s   = LATW'(0);
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= LATW'(0);
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign mc_stall = mc_stall_s;
  assign mc_busy  = (state_r == MC_BUSY);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: forwarding, load-use, branch flush, multi-cycle and
// memory-wait hazard control for a 5-stage F/D/E/M/W pipeline.
//   clk, rst - clock, synchronous active-high reset
//   hz       - slave side of hazard_scoreboard_unit_if: stage addresses and
//              enables in; operand forward selects, per-stage stall/flush,
//              mcBusy and the saturating stall-cycle counter out
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int ADDRESSWIDTH = 4,
  parameter int MAXLATENCY   = 8,
  parameter int ZEROREG_EN   = 0,
  parameter int COUNTWIDTH   = 16
) (
  input logic                     clk,
  input logic                     rst,
  hazard_scoreboard_unit_if.slave hz
);
  localparam logic ZERO_EN = (ZEROREG_EN != 32'sd0);

  fwd_sel_t              fwd1_s;
  fwd_sel_t              fwd2_s;
  logic                  mem_stall_s;
  logic                  ld_stall_s;
  logic                  branch_s;
  logic                  mc_stall_s;
  logic                  mc_busy_s;
  logic                  stall_f_s;
  logic                  stall_d_s;
  logic                  stall_e_s;
  logic                  stall_m_s;
  logic                  flush_d_s;
  logic                  flush_e_s;
  logic                  flush_m_s;
  logic                  flush_w_s;
  logic [COUNTWIDTH-1:0] stall_count_r;

  function automatic logic hit(input logic [ADDRESSWIDTH-1:0] a,
                               input logic [ADDRESSWIDTH-1:0] b);
    return reg_match(ADDR_MAX_W'(a), ADDR_MAX_W'(b), ZERO_EN);
  endfunction

  mc_latency_counter #(
    .MAXLATENCY (MAXLATENCY)
  ) u_mc (
    .clk         (clk),
    .rst         (rst),
    .multi_cycle (hz.multiCycleE),
    .latency     (hz.latencyE),
    .mem_stall   (mem_stall_s),
    .mc_stall    (mc_stall_s),
    .mc_busy     (mc_busy_s)
  );

  // Operand forwarding: the younger result in M wins over W.
  always_comb begin
    fwd1_s = FWD_REG;
    fwd2_s = FWD_REG;
    if (rst) begin
      fwd1_s = FWD_REG;
      fwd2_s = FWD_REG;
    end else begin
      if (hz.writeEnableM && hit(hz.reg1ReadAddressE, hz.writeAddressM)) begin
        fwd1_s = FWD_MEM;
      end else if (hz.writeEnableW && hit(hz.reg1ReadAddressE, hz.writeAddressW)) begin
        fwd1_s = FWD_WB;
      end else begin
        fwd1_s = FWD_REG;
      end
      if (hz.writeEnableM && hit(hz.reg2ReadAddressE, hz.writeAddressM)) begin
        fwd2_s = FWD_MEM;
      end else if (hz.writeEnableW && hit(hz.reg2ReadAddressE, hz.writeAddressW)) begin
        fwd2_s = FWD_WB;
      end else begin
        fwd2_s = FWD_REG;
      end
    end
  end

  // Hazard sources; a memory wait freezes the whole pipe and masks the rest.
  always_comb begin
    mem_stall_s = hz.memAccessM & ~hz.memReadyM;
    ld_stall_s  = hz.writeEnableE & hz.resultSelectorWBE &
                  (hit(hz.reg1ReadAddressD, hz.writeAddressE) |
                   hit(hz.reg2ReadAddressD, hz.writeAddressE));
    branch_s    = hz.takeBranchE & ~mem_stall_s;
  end

  // Stall/flush composition, forced quiet while in reset.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_m_s = 1'b0;
    flush_w_s = 1'b0;
    if (rst) begin
      stall_f_s = 1'b0;
    end else begin
      // A taken branch discards F/D anyway, so it releases their stalls.
      stall_f_s = mem_stall_s | ((ld_stall_s | mc_stall_s) & ~branch_s);
      stall_d_s = stall_f_s;
      stall_e_s = mem_stall_s | mc_stall_s;
      stall_m_s = mem_stall_s;
      flush_d_s = branch_s;
      flush_e_s = branch_s | (ld_stall_s & ~mem_stall_s);
      flush_m_s = mc_stall_s & ~mem_stall_s;
      flush_w_s = mem_stall_s;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= {COUNTWIDTH{1'b0}};
    end else if (stall_f_s && (stall_count_r != {COUNTWIDTH{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(COUNTWIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign hz.data1ForwardSelectorE = fwd1_s;
  assign hz.data2ForwardSelectorE = fwd2_s;
  assign hz.stallF     = stall_f_s;
  assign hz.stallD     = stall_d_s;
  assign hz.stallE     = stall_e_s;
  assign hz.stallM     = stall_m_s;
  assign hz.flushD     = flush_d_s;
  assign hz.flushE     = flush_e_s;
  assign hz.flushM     = flush_m_s;
  assign hz.flushW     = flush_w_s;
  assign hz.mcBusy     = mc_busy_s;
  assign hz.stallCount = stall_count_r;

endmodule
